// File: rtl/detect_event_logger_pkg.sv
// Shared defaults and types for the detection event logger.
package detect_pkg;

    localparam int TS_W_DEFAULT  = 16;
    localparam int DEPTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

    typedef logic [TS_W_DEFAULT-1:0] ts_t;

endpackage

// File: rtl/detect_event_logger_if.sv
// Bus between the event logger and its environment: detector input,
// counter clear, and the first-word-fall-through timestamp stream.
interface detect_event_logger_if
    import detect_pkg::*;
#(
    parameter int TS_W  = TS_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             det_in;
    logic             clr_cnt;
    logic             out_ready;
    logic             out_valid;
    logic [TS_W-1:0]  out_data;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    modport master (
        output det_in, clr_cnt, out_ready,
        input  out_valid, out_data, evt_count, overflow
    );

    modport slave (
        input  det_in, clr_cnt, out_ready,
        output out_valid, out_data, evt_count, overflow
    );

endinterface

// File: rtl/detect_event_logger_fifo.sv
// First-word-fall-through FIFO holding event timestamps. Pointers carry
// one extra wrap bit so full and empty can be told apart without a counter.
module event_fifo
    import detect_pkg::*;
#(
    parameter int WIDTH = TS_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps rising edges of a sequence-detector output, queues them in a
// small FIFO and keeps a saturating event count plus a sticky drop flag.
module detect_event_logger
    import detect_pkg::*;
#(
    parameter int TS_W  = TS_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic clk,
    input logic reset,
    detect_event_logger_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  ts;
    logic             det_q;
    logic [CNT_W-1:0] evt_count_q;
    logic             overflow_q;
    logic             evt;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TS_W-1:0]  fifo_head;

    assign evt  = bus.det_in && !det_q;
    assign pop  = !fifo_empty && bus.out_ready;
    assign drop = evt && fifo_full && !pop;
    assign push = evt && !drop;

    // Free-running timestamp and the delayed detector sample for edge finding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts    <= '0;
            det_q <= 1'b0;
        end else begin
            ts    <= ts + {{(TS_W-1){1'b0}}, 1'b1};
            det_q <= bus.det_in;
        end
    end

    // Event counter saturates; clear wins but still counts a coincident event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_count_q <= '0;
            overflow_q  <= 1'b0;
        end else if (bus.clr_cnt) begin
            evt_count_q <= evt ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            overflow_q  <= drop;
        end else begin
            if (evt && evt_count_q != CNT_MAX)
                evt_count_q <= evt_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (ts),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;
    assign bus.evt_count = evt_count_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_detect_event_logger;
    import detect_pkg::*;

    localparam int TS_W    = TS_W_DEFAULT;
    localparam int DEPTH   = DEPTH_DEFAULT;
    localparam int CNT_W   = CNT_W_DEFAULT;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    detect_event_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

    detect_event_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int mts;
    bit mprev;
    int q[$];
    int mcount;
    bit movf;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mts    = 0;
        mprev  = 0;
        q.delete();
        mcount = 0;
        movf   = 0;
    endtask

    task automatic modelStep(input bit d, input bit c, input bit r);
        bit evt, pop, drop;
        evt  = d && !mprev;
        pop  = (q.size() > 0) && r;
        drop = evt && (q.size() == DEPTH) && !pop;
        if (pop) void'(q.pop_front());
        if (evt && !drop) q.push_back(mts);
        if (c) begin
            mcount = evt ? 1 : 0;
            movf   = drop;
        end else begin
            if (evt && mcount < CNT_MAX) mcount++;
            if (drop) movf = 1;
        end
        mts   = (mts + 1) % (1 << TS_W);
        mprev = d;
    endtask

    task automatic compareAll();
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0)
            checkOutput("out_data", {{(32-TS_W){1'b0}}, bus.out_data}, q[0]);
        checkOutput("evt_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, mcount);
        checkOutput("overflow", {31'b0, bus.overflow}, {31'b0, movf});
    endtask

    task automatic applyStimulus(input bit d, input bit c, input bit r);
        bus.det_in    = d;
        bus.clr_cnt   = c;
        bus.out_ready = r;
        @(posedge clk);
        modelStep(d, c, r);
        #1;
        compareAll();
    endtask

    task automatic doReset(input bit detAtRelease);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", {31'b0, bus.out_valid}, 0);
        checkOutput("async_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, 0);
        checkOutput("async_ovf", {31'b0, bus.overflow}, 0);
        modelReset();
        bus.det_in    = 1'b0;
        bus.clr_cnt   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold_valid", {31'b0, bus.out_valid}, 0);
        @(negedge clk);
        bus.det_in = detAtRelease;
        reset      = 1'b0;
    endtask

    task automatic drainAndClear();
        repeat (DEPTH + 1) applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 1);
    endtask

    initial begin
        bit d, r;
        reset         = 1'b1;
        bus.det_in    = 1'b0;
        bus.clr_cnt   = 1'b0;
        bus.out_ready = 1'b0;
        modelReset();

        doReset(0);

        // pulses where ts = 5 and ts = 9, consumer always ready
        for (int i = 0; i < 14; i++) begin
            d = (mts == 5) || (mts == 9);
            applyStimulus(d, 0, 1);
        end
        checkOutput("two_pulse_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, 2);

        // five pulses with consumer stalled, then drain in order
        drainAndClear();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0);
            applyStimulus(0, 0, 0);
        end
        checkOutput("stall_ovf", {31'b0, bus.overflow}, 1);
        checkOutput("stall_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, 5);
        checkOutput("stall_qsize", q.size(), DEPTH);
        repeat (DEPTH + 1) applyStimulus(0, 0, 1);
        checkOutput("drained_valid", {31'b0, bus.out_valid}, 0);

        // full FIFO with pop and push in the same cycle
        applyStimulus(0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 0);
            applyStimulus(0, 0, 0);
        end
        applyStimulus(1, 0, 1);
        checkOutput("full_pp_ovf", {31'b0, bus.overflow}, 0);
        checkOutput("full_pp_qsize", q.size(), DEPTH);
        drainAndClear();

        // held-high detector produces a single event
        repeat (3) applyStimulus(1, 0, 1);
        repeat (2) applyStimulus(0, 0, 1);
        checkOutput("held_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, 1);

        // counter saturation
        for (int i = 0; i < 300; i++) begin
            r = 1'($urandom_range(0, 1));
            applyStimulus(1, 0, r);
            applyStimulus(0, 0, r);
        end
        checkOutput("sat_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, CNT_MAX);

        // clear coincident with an event
        applyStimulus(1, 1, 1);
        checkOutput("clr_evt_count", {{(32-CNT_W){1'b0}}, bus.evt_count}, 1);
        drainAndClear();

        // reset with three entries queued; detector high at release
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            applyStimulus(0, 0, 0);
        end
        checkOutput("pre_rst_qsize", q.size(), 3);
        doReset(1);
        applyStimulus(1, 0, 0);
        checkOutput("release_evt_data", {{(32-TS_W){1'b0}}, bus.out_data}, 0);
        applyStimulus(0, 0, 1);

        // random traffic with stall phases and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500 || i == 3100) doReset(1'($urandom_range(0, 1)));
            d = ($urandom_range(0, 9) < 4);
            r = ((i % 200) < 70) ? 1'b0 : 1'($urandom_range(0, 1));
            applyStimulus(d, ($urandom_range(0, 63) == 0), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
